forward_grant_ctrl: RTL and testbench

Per-port forwarding-window scheduler that sits directly upstream of each port's forward packet module. It answers that module's forward request with a one-cycle response and a byte budget, aligned to the optical-switch slot schedule. It then tracks the granted window until the module reports completion or the window expires. One instance per port, in that port's AXI clock domain.

---
 rtl/forward_grant_ctrl.sv | 114 +++++++++++
 tb/tb_forward_grant_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/forward_grant_ctrl.sv
// rtl/forward_grant_ctrl.sv - per-port forwarding-window scheduler aligned to switch slots
module forward_grant_ctrl #(
    parameter int P_GUARD_CYCLES    = 16,
    parameter int P_BYTES_PER_CYCLE = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_slot_start,
    input  logic [15:0] i_slot_cycles,
    input  logic        i_slot_enable,
    input  logic        i_forward_req,
    output logic        o_forward_resp,
    output logic [31:0] o_forward_byte,
    output logic        o_forward_byte_valid,
    input  logic        i_forward_finish,
    output logic        o_busy,
    output logic [15:0] o_grant_cnt,
    output logic [15:0] o_timeout_cnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT  = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    localparam logic [31:0] GUARD = 32'(P_GUARD_CYCLES);
    localparam logic [31:0] BPC   = 32'(P_BYTES_PER_CYCLE);

    state_t      state;
    logic        pending;
    logic [15:0] win_cnt;
    logic [31:0] slot_ext;
    logic [31:0] budget;
    logic        grant_now;

    // Byte budget for the slot being offered; zero when the guard eats the whole slot
    always_comb begin
        slot_ext = {16'd0, i_slot_cycles};
        budget   = 32'd0;
        if (slot_ext > GUARD) begin
            budget = (slot_ext - GUARD) * BPC;
        end
    end

    assign grant_now = (state == S_IDLE) && i_slot_start && pending &&
                       i_slot_enable && (budget != 32'd0);

    // Pending request flag: a new request wins over the clear in the grant cycle
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            pending <= 1'b0;
        end else if (i_forward_req) begin
            pending <= 1'b1;
        end else if (state == S_GRANT) begin
            pending <= 1'b0;
        end
    end

    // Window FSM with registered grant, budget, busy and statistics outputs
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state                <= S_IDLE;
            win_cnt              <= 16'd0;
            o_forward_resp       <= 1'b0;
            o_forward_byte       <= 32'd0;
            o_forward_byte_valid <= 1'b0;
            o_busy               <= 1'b0;
            o_grant_cnt          <= 16'd0;
            o_timeout_cnt        <= 16'd0;
        end else begin
            o_forward_resp       <= 1'b0;
            o_forward_byte_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_now) begin
                        state                <= S_GRANT;
                        win_cnt              <= i_slot_cycles;
                        o_forward_resp       <= 1'b1;
                        o_forward_byte_valid <= 1'b1;
                        o_forward_byte       <= budget;
                        o_busy               <= 1'b1;
                    end
                end
                S_GRANT: begin
                    // win_cnt already holds the slot length; it starts counting in ACTIVE
                    state <= S_ACTIVE;
                    if (o_grant_cnt != 16'hFFFF) begin
                        o_grant_cnt <= o_grant_cnt + 16'd1;
                    end
                end
                S_ACTIVE: begin
                    win_cnt <= win_cnt - 16'd1;
                    if (i_forward_finish) begin
                        state  <= S_IDLE;
                        o_busy <= 1'b0;
                    end else if (i_slot_start || (win_cnt == 16'd1)) begin
                        // Expiry or a slot boundary overrunning the window: the slot_start is consumed
                        state  <= S_IDLE;
                        o_busy <= 1'b0;
                        if (o_timeout_cnt != 16'hFFFF) begin
                            o_timeout_cnt <= o_timeout_cnt + 16'd1;
                        end
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_forward_grant_ctrl.sv
// tb/tb_forward_grant_ctrl.sv - scoreboard bench for forward_grant_ctrl
module tb_forward_grant_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        slot_start = 1'b0;
    logic [15:0] slot_cycles = 16'd0;
    logic        slot_enable = 1'b1;
    logic        forward_req = 1'b0;
    logic        forward_resp;
    logic [31:0] forward_byte;
    logic        forward_byte_valid;
    logic        forward_finish = 1'b0;
    logic        busy;
    logic [15:0] grant_cnt;
    logic [15:0] timeout_cnt;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] byte_val;
        int          cycle;
    } exp_t;

    exp_t exp_q[$];

    forward_grant_ctrl #(
        .P_GUARD_CYCLES(16),
        .P_BYTES_PER_CYCLE(8)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_slot_start(slot_start),
        .i_slot_cycles(slot_cycles),
        .i_slot_enable(slot_enable),
        .i_forward_req(forward_req),
        .o_forward_resp(forward_resp),
        .o_forward_byte(forward_byte),
        .o_forward_byte_valid(forward_byte_valid),
        .i_forward_finish(forward_finish),
        .o_busy(busy),
        .o_grant_cnt(grant_cnt),
        .o_timeout_cnt(timeout_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: every grant pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (forward_resp === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got resp at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_byte", forward_byte, e.byte_val);
                chk("resp_valid", {31'd0, forward_byte_valid}, 32'd1);
                chk("resp_cycle", cyc, e.cycle);
            end
        end
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic req_pulse();
        forward_req = 1'b1;
        step();
        forward_req = 1'b0;
    endtask

    task automatic slot(input logic [15:0] n, input bit expect_grant, input logic [31:0] bytes);
        exp_t e;
        if (expect_grant) begin
            e.byte_val = bytes;
            e.cycle    = cyc + 1;
            exp_q.push_back(e);
        end
        slot_start  = 1'b1;
        slot_cycles = n;
        step();
        slot_start  = 1'b0;
    endtask

    task automatic finish_pulse();
        forward_finish = 1'b1;
        step();
        forward_finish = 1'b0;
    endtask

    initial begin
        step(3);
        chk("rst_resp", {31'd0, forward_resp}, 32'd0);
        chk("rst_valid", {31'd0, forward_byte_valid}, 32'd0);
        chk("rst_byte", forward_byte, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_gcnt", {16'd0, grant_cnt}, 32'd0);
        chk("rst_tcnt", {16'd0, timeout_cnt}, 32'd0);
        rst = 1'b1;
        step(2);

        // Basic grant then finish
        req_pulse();
        step(4);
        slot(16'd1000, 1'b1, 32'd7872);
        chk("basic_busy_grant", {31'd0, busy}, 32'd1);
        step();
        chk("basic_gcnt", {16'd0, grant_cnt}, 32'd1);
        step(20);
        chk("basic_busy_active", {31'd0, busy}, 32'd1);
        finish_pulse();
        chk("basic_busy_after_finish", {31'd0, busy}, 32'd0);
        chk("basic_tcnt", {16'd0, timeout_cnt}, 32'd0);
        chk("basic_byte_hold", forward_byte, 32'd7872);
        chk("basic_valid_low", {31'd0, forward_byte_valid}, 32'd0);

        // Window expiry with no finish
        req_pulse();
        slot(16'd100, 1'b1, 32'd672);
        step(100);
        chk("to_busy_last", {31'd0, busy}, 32'd1);
        step();
        chk("to_busy_end", {31'd0, busy}, 32'd0);
        chk("to_tcnt", {16'd0, timeout_cnt}, 32'd1);
        chk("to_gcnt", {16'd0, grant_cnt}, 32'd2);

        // Slots at or below the guard are skipped and pending survives
        req_pulse();
        slot(16'd16, 1'b0, 32'd0);
        chk("small16_busy", {31'd0, busy}, 32'd0);
        step(2);
        slot(16'd10, 1'b0, 32'd0);
        chk("small10_busy", {31'd0, busy}, 32'd0);
        step(2);
        slot(16'd200, 1'b1, 32'd1472);
        step(5);
        finish_pulse();
        chk("small_gcnt", {16'd0, grant_cnt}, 32'd3);

        // Early slot_start during ACTIVE counts a timeout and is consumed
        req_pulse();
        slot(16'd300, 1'b1, 32'd2272);
        step(5);
        req_pulse();
        step(3);
        slot(16'd300, 1'b0, 32'd0);
        chk("early_busy", {31'd0, busy}, 32'd0);
        chk("early_tcnt", {16'd0, timeout_cnt}, 32'd2);
        slot(16'd300, 1'b1, 32'd2272);
        step(4);
        finish_pulse();
        chk("early_gcnt", {16'd0, grant_cnt}, 32'd5);

        // Finish on the final window cycle wins over expiry
        req_pulse();
        slot(16'd50, 1'b1, 32'd272);
        step(50);
        chk("sim_busy_last", {31'd0, busy}, 32'd1);
        finish_pulse();
        chk("sim_busy_end", {31'd0, busy}, 32'd0);
        chk("sim_tcnt", {16'd0, timeout_cnt}, 32'd2);

        // Disabled slots do not grant; finish outside ACTIVE is ignored
        req_pulse();
        slot_enable = 1'b0;
        slot(16'd200, 1'b0, 32'd0);
        chk("dis_busy", {31'd0, busy}, 32'd0);
        finish_pulse();
        slot_enable = 1'b1;
        step(2);
        slot(16'd200, 1'b1, 32'd1472);
        step(3);
        finish_pulse();
        chk("dis_gcnt", {16'd0, grant_cnt}, 32'd7);
        chk("dis_tcnt", {16'd0, timeout_cnt}, 32'd2);

        // Reset in the middle of a window
        req_pulse();
        slot(16'd200, 1'b1, 32'd1472);
        step(5);
        rst = 1'b0;
        step();
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_gcnt", {16'd0, grant_cnt}, 32'd0);
        chk("mid_rst_tcnt", {16'd0, timeout_cnt}, 32'd0);
        chk("mid_rst_byte", forward_byte, 32'd0);
        rst = 1'b1;
        step();
        req_pulse();
        slot(16'd200, 1'b1, 32'd1472);
        step();
        chk("post_rst_gcnt", {16'd0, grant_cnt}, 32'd1);
        step(3);
        finish_pulse();

        step(5);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
